// File: rtl/reset_seq.sv
// reset_seq: staged reset sequencer driven by a clock-generator lock indication.
//
// Ports:
//   clk             in   1x clock from the clock generator
//   rst_n           in   asynchronous active-low reset
//   locked_in       in   lock indication, asynchronous to clk
//   rst_out         out  STAGES active-high synchronous resets, bit 0 released first
//   ready           out  high once every stage has been released
//   lock_loss_count out  saturating count of lock drops seen outside IDLE
module reset_seq #(
    parameter int HOLD_CYCLES = 1024,
    parameter int STAGES      = 3,
    parameter int STAGE_GAP   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              locked_in,
    output logic [STAGES-1:0] rst_out,
    output logic              ready,
    output logic [7:0]        lock_loss_count
);
    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    localparam int GW = STAGE_GAP > 1 ? $clog2(STAGE_GAP) : 1;
    localparam int IW = STAGES > 1 ? $clog2(STAGES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(STAGES - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] HOLD    = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;
    localparam logic [1:0] RUN     = 2'd3;

    logic          sync1;
    logic          locked_s;
    logic [1:0]    state;
    logic [HW-1:0] hold_cnt;
    logic [GW-1:0] gap_cnt;
    logic [IW-1:0] idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync1    <= locked_in;
            locked_s <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            rst_out         <= '1;
            ready           <= 1'b0;
            lock_loss_count <= 8'd0;
            hold_cnt        <= '0;
            gap_cnt         <= '0;
            idx             <= '0;
        end else if (state != IDLE && !locked_s) begin
            // Lock drop outranks any release due on this same edge.
            state    <= IDLE;
            rst_out  <= '1;
            ready    <= 1'b0;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            idx      <= '0;
            if (lock_loss_count != 8'hff)
                lock_loss_count <= lock_loss_count + 8'd1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (locked_s) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        // rst_out is all ones here, so clearing bit 0 is a mask.
                        rst_out <= rst_out & ~STAGES'(1);
                        gap_cnt <= '0;
                        if (STAGES == 1) begin
                            state <= RUN;
                            ready <= 1'b1;
                        end else begin
                            state <= RELEASE;
                            idx   <= IW'(1);
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                RELEASE: begin
                    if (gap_cnt == GAP_LAST) begin
                        rst_out <= rst_out & ~(STAGES'(1) << idx);
                        gap_cnt <= '0;
                        if (idx == IDX_LAST) begin
                            state <= RUN;
                            ready <= 1'b1;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                RUN: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reset_seq.sv
// tb_reset_seq: randomized scoreboard bench for reset_seq (3-stage and 1-stage builds).
module tb_reset_seq;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       locked_in = 1'b0;
    logic [2:0] rst_out3;
    logic       ready3;
    logic [7:0] cnt3;
    logic [0:0] rst_out1;
    logic       ready1;
    logic [7:0] cnt1;

    int total = 0;
    int bad = 0;

    reset_seq #(.HOLD_CYCLES(H), .STAGES(3), .STAGE_GAP(4)) u3 (
        .clk(clk), .rst_n(rst_n), .locked_in(locked_in),
        .rst_out(rst_out3), .ready(ready3), .lock_loss_count(cnt3)
    );

    reset_seq #(.HOLD_CYCLES(H), .STAGES(1), .STAGE_GAP(1)) u1 (
        .clk(clk), .rst_n(rst_n), .locked_in(locked_in),
        .rst_out(rst_out1), .ready(ready1), .lock_loss_count(cnt1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r3;
        int rdy3;
        int r1;
        int rdy1;
        int cnt;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Stages released after `since` cycles in HOLD-or-later: first after H, then every g.
    function automatic int released(input int since, input int s, input int g);
        int n;
        if (since < H) return 0;
        n = 1 + (since - H) / g;
        return n > s ? s : n;
    endfunction

    // Reference model: the lock signal seen by the sequencer is locked_in two edges late.
    int m_hist[$] = '{0, 0};
    int m_active = 0;
    int m_since = 0;
    int m_cnt = 0;

    function automatic exp_t expect_now();
        exp_t e;
        int n3, n1;
        n3 = m_active ? released(m_since, 3, 4) : 0;
        n1 = m_active ? released(m_since, 1, 1) : 0;
        e.r3 = 7 & ~((1 << n3) - 1);
        e.rdy3 = (n3 == 3);
        e.r1 = 1 & ~((1 << n1) - 1);
        e.rdy1 = (n1 == 1);
        e.cnt = m_cnt;
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hist = '{0, 0};
            m_active = 0;
            m_since = 0;
            m_cnt = 0;
            sb.delete();
            sb.push_back(expect_now());
        end else begin
            int ls;
            ls = m_hist[0];
            if (!m_active) begin
                if (ls != 0) begin
                    m_active = 1;
                    m_since = 0;
                end
            end else if (ls == 0) begin
                m_active = 0;
                if (m_cnt < 255) m_cnt++;
            end else begin
                m_since++;
            end
            void'(m_hist.pop_front());
            m_hist.push_back(int'(locked_in));
            sb.push_back(expect_now());
        end
    end

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("rst_out3", int'(rst_out3), e.r3);
            chk("ready3", int'(ready3), e.rdy3);
            chk("count3", int'(cnt3), e.cnt);
            chk("rst_out1", int'(rst_out1), e.r1);
            chk("ready1", int'(ready1), e.rdy1);
            chk("count1", int'(cnt1), e.cnt);
        end
    end

    task automatic cyc(input int n, input logic v);
        locked_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Entered at posedge+1; asserts rst_n across the following falling clock edge.
    task automatic rst_pulse();
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!ready3 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ready_timeout", int'(ready3), 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rst_out", int'(rst_out3), 7);
        chk("reset_ready", int'(ready3), 0);
        chk("reset_count", int'(cnt3), 0);
        rst_n = 1'b1;

        // Basic sequence, then loss in RUN and re-lock.
        cyc(3, 1'b0);
        cyc(25, 1'b1);
        wait_ready(10);
        cyc(3, 1'b0);
        cyc(25, 1'b1);
        chk("run_relock_count", int'(cnt3), 1);

        // Glitch during hold.
        rst_pulse();
        cyc(3, 1'b0);
        cyc(5, 1'b1);
        cyc(1, 1'b0);
        cyc(20, 1'b1);

        // Async reset between edges 14 and 15 of a fresh sequence.
        rst_pulse();
        cyc(3, 1'b0);
        cyc(15, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out", int'(rst_out3), 7);
        chk("async_ready", int'(ready3), 0);
        chk("async_count", int'(cnt3), 0);
        #3 rst_n = 1'b1;
        cyc(25, 1'b1);

        // Saturation: 300 drops, each after HOLD has been entered.
        repeat (300) begin
            cyc(3, 1'b1);
            cyc(3, 1'b0);
        end
        chk("sat_count", int'(cnt3), 255);
        chk("sat_count1", int'(cnt1), 255);

        // Randomized lock waveforms with occasional async resets.
        rst_pulse();
        repeat (60) begin
            cyc($urandom_range(1, 40), 1'b1);
            cyc($urandom_range(1, 4), 1'b0);
            if ($urandom_range(0, 7) == 0) rst_pulse();
        end
        cyc(30, 1'b1);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
